aes_out_capture: RTL and testbench

- Downstream consumer of the AES top-level datapath.
- Samples the 128-bit cipher output whenever the observe strobe is high and buffers the samples in a small FIFO.
- Streams each buffered sample out as four 32-bit beats over a valid/ready interface.
- Maintains a running 128-bit MISR signature plus capture/drop statistics, so long runs can be checked against a single golden value.

---
 rtl/aes_out_capture.sv | 90 +++++++++
 tb/tb_aes_out_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_capture.sv
// Captures AES cipher output samples into a small FIFO, streams them as four
// 32-bit beats (MSW first) and keeps a MISR signature plus capture/drop stats.
module aes_out_capture #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     out,
  input  logic             __obs,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     signature,
  output logic [CNT_W-1:0] capture_count,
  output logic [7:0]       drop_count,
  output logic             overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    word_idx;

  logic          beat;
  logic          last;
  logic          full;
  logic          push;
  logic          drop;
  logic [127:0]  misr_next;
  logic [127:0]  head;

  assign m_valid = (count != '0);
  assign beat    = m_valid && m_ready;
  assign last    = beat && (word_idx == 2'd3);
  assign full    = (count == CW'(DEPTH));
  // A full FIFO still accepts a sample when the head's final beat leaves on the same edge.
  assign push    = __obs && (!full || last);
  assign drop    = __obs && !push;

  assign misr_next = ({signature[126:0], 1'b0} ^ (signature[127] ? 128'h87 : 128'h0)) ^ out;

  always_comb begin
    head   = mem[rd_ptr];
    m_data = '0;
    if (m_valid) begin
      case (word_idx)
        2'd0:    m_data = head[127:96];
        2'd1:    m_data = head[95:64];
        2'd2:    m_data = head[63:32];
        default: m_data = head[31:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      word_idx      <= '0;
      signature     <= '0;
      capture_count <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      if (beat) word_idx <= word_idx + 2'd1;
      if (last) rd_ptr <= rd_ptr + AW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (capture_count != '1) capture_count <= capture_count + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 8'd1;
      end
      count <= count + CW'(push) - CW'(last);
      if (__obs) signature <= misr_next;
    end
  end

endmodule

// File: tb/tb_aes_out_capture.sv
// Self-checking bench for aes_out_capture: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_aes_out_capture;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [127:0]     out_v;
  logic             obs;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic [127:0]     signature;
  logic [CNT_W-1:0] capture_count;
  logic [7:0]       drop_count;
  logic             overflow;

  aes_out_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .out(out_v), .__obs(obs),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .signature(signature), .capture_count(capture_count),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [127:0] q[$];
  int unsigned  widx;
  longint unsigned ref_cap;
  int unsigned  ref_drop;
  bit           ref_ovf;
  logic [127:0] ref_sig;

  localparam logic [127:0] VEC = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] gf_mul_x_add(input logic [127:0] s, input logic [127:0] o);
    logic [127:0] r;
    r = s << 1;
    if (s[127]) r = r ^ 128'h87;
    return r ^ o;
  endfunction

  function automatic logic [31:0] ref_data();
    logic [127:0] h;
    if (q.size() == 0) return 32'h0;
    h = q[0];
    return h[127 - 32*widx -: 32];
  endfunction

  task automatic model_reset();
    q.delete();
    widx = 0; ref_cap = 0; ref_drop = 0; ref_ovf = 0; ref_sig = '0;
  endtask

  task automatic model_step(input logic o_bs, input logic [127:0] o, input logic rdy, input logic r);
    bit popped;
    if (r) begin
      model_reset();
      return;
    end
    popped = 0;
    if (q.size() != 0 && rdy) begin
      if (widx == 3) begin popped = 1; widx = 0; end
      else widx++;
    end
    if (popped) void'(q.pop_front());
    if (o_bs) begin
      if (q.size() < DEPTH) begin
        q.push_back(o);
        if (ref_cap < (64'd1 << CNT_W) - 1) ref_cap++;
      end else begin
        ref_ovf = 1;
        if (ref_drop < 255) ref_drop++;
      end
      ref_sig = gf_mul_x_add(ref_sig, o);
    end
  endtask

  // One clock: apply inputs, compare every output with the model, then advance both.
  task automatic cycle(input logic o_bs, input logic [127:0] o, input logic rdy, input logic r);
    obs = o_bs; out_v = o; m_ready = rdy; rst = r;
    check("m_valid",   128'(m_valid),       128'(q.size() != 0));
    check("m_data",    128'(m_data),        128'(ref_data()));
    check("signature", signature,           ref_sig);
    check("cap_count", 128'(capture_count), 128'(ref_cap));
    check("drop_count",128'(drop_count),    128'(ref_drop));
    check("overflow",  128'(overflow),      128'(ref_ovf));
    model_step(o_bs, o, rdy, r);
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [31:0] basic_words [4];

  initial begin
    basic_words[0] = 32'h00112233; basic_words[1] = 32'h44556677;
    basic_words[2] = 32'h8899AABB; basic_words[3] = 32'hCCDDEEFF;
    rst = 1'b1; obs = 1'b0; out_v = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    check("rst_valid", 128'(m_valid), 128'(0));
    check("rst_data",  128'(m_data),  128'(0));
    check("rst_sig",   signature,     128'(0));
    check("rst_ovf",   128'(overflow), 128'(0));

    // Basic capture and stream
    cycle(1, VEC, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check("basic_valid", 128'(m_valid), 128'(1));
      check("basic_data",  128'(m_data),  128'(basic_words[i]));
      cycle(0, '0, 1, 0);
    end
    check("basic_done",  128'(m_valid),       128'(0));
    check("basic_count", 128'(capture_count), 128'(1));

    // Overflow: five captures into four slots with the sink stalled
    cycle(0, '0, 0, 1);
    for (int i = 1; i <= 5; i++) cycle(1, 128'(i), 0, 0);
    check("ovf_cap",  128'(capture_count), 128'(4));
    check("ovf_drop", 128'(drop_count),    128'(1));
    check("ovf_flag", 128'(overflow),      128'(1));
    for (int k = 0; k < 16; k++) begin
      check("ovf_drain", 128'(m_data), (k % 4 == 3) ? 128'(k / 4 + 1) : 128'(0));
      cycle(0, '0, 1, 0);
    end
    check("ovf_empty", 128'(m_valid), 128'(0));

    // Backpressure during word 1
    cycle(0, '0, 0, 1);
    cycle(1, VEC, 1, 0);
    cycle(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_data",  128'(m_data),  128'(32'h44556677));
      check("bp_valid", 128'(m_valid), 128'(1));
      cycle(0, '0, 0, 0);
    end
    check("bp_hold", 128'(m_data), 128'(32'h44556677));
    cycle(0, '0, 1, 0);
    check("bp_resume", 128'(m_data), 128'(32'h8899AABB));
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Full FIFO accepts a push on the edge its head's final beat leaves
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, rnd128(), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    cycle(1, 128'hFEED, 1, 0);
    check("fp_ovf",  128'(overflow),      128'(0));
    check("fp_cap",  128'(capture_count), 128'(5));
    check("fp_drop", 128'(drop_count),    128'(0));
    for (int i = 0; i < 16; i++) cycle(0, '0, 1, 0);
    check("fp_empty", 128'(m_valid), 128'(0));

    // MISR known values
    cycle(0, '0, 1, 1);
    cycle(1, 128'h1, 1, 0);
    check("misr_1", signature, 128'h1);
    cycle(1, 128'h1, 1, 0);
    check("misr_3", signature, 128'h3);
    cycle(0, '0, 1, 1);
    cycle(1, {1'b1, 127'h0}, 1, 0);
    check("misr_msb", signature, {1'b1, 127'h0});
    cycle(1, '0, 1, 0);
    check("misr_fb", signature, 128'h87);
    for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0);

    // Reset while word 2 is stalled
    cycle(0, '0, 1, 1);
    cycle(1, VEC, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    check("mid_w2", 128'(m_data), 128'(32'h8899AABB));
    cycle(0, '0, 0, 1);
    check("mid_valid", 128'(m_valid),       128'(0));
    check("mid_data",  128'(m_data),        128'(0));
    check("mid_sig",   signature,           128'(0));
    check("mid_cap",   128'(capture_count), 128'(0));
    check("mid_drop",  128'(drop_count),    128'(0));
    check("mid_ovf",   128'(overflow),      128'(0));
    cycle(1, VEC, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check("mid_restart", 128'(m_data), 128'(basic_words[i]));
      cycle(0, '0, 1, 0);
    end

    // Drop counter saturation
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 300; i++) cycle(1, rnd128(), 0, 0);
    check("drop_sat", 128'(drop_count), 128'(8'hFF));
    check("sat_ovf",  128'(overflow),   128'(1));

    // Random traffic
    cycle(0, '0, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) == 0) ? 128'($urandom_range(0, 15)) : rnd128(),
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
